// File: rtl/register_bank_pkg.sv
// Shared widths and write-buffer state encoding for the register bank.
package register_bank_pkg;
  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 3;
  localparam int NUM_REGS   = 8;

  typedef enum logic {
    WB_EMPTY = 1'b0,
    WB_FULL  = 1'b1
  } wb_state_e;
endpackage

// File: rtl/regbank_write_buffer.sv
// One-entry write-back buffer: holds addr/data, raises commit one cycle after
// acceptance unless hold is asserted.
module regbank_write_buffer
  import register_bank_pkg::*;
#(
  parameter int DATA_W = register_bank_pkg::DATA_W
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  wr_valid,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  hold,
  output logic                  wr_ready,
  output logic                  commit,
  output logic [REG_ADDR_W-1:0] buf_addr,
  output logic [DATA_W-1:0]     buf_data,
  output wb_state_e             state
);
  // Handshake: a write transfers on a rising edge where wr_valid and wr_ready
  // are both 1; while wr_valid=1 and wr_ready=0 the requester holds
  // wr_valid/wr_addr/wr_data stable.
  wb_state_e state_q, state_d;
  logic      accept;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= WB_EMPTY;
      buf_addr <= '0;
      buf_data <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        buf_addr <= wr_addr;
        buf_data <= wr_data;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_ready = 1'b1;
    commit   = 1'b0;
    case (state_q)
      WB_EMPTY: begin
        if (wr_valid) state_d = WB_FULL;
      end
      WB_FULL: begin
        // Commit and refill on the same edge keeps full throughput.
        wr_ready = !hold;
        commit   = !hold;
        if (!hold && !wr_valid) state_d = WB_EMPTY;
      end
      default: state_d = WB_EMPTY;
    endcase
    accept = wr_valid && wr_ready;
  end

  assign state = state_q;
endmodule

// File: rtl/register_bank.sv
// GPRs r0..r7 plus auxiliary R register with buffered write-back.
// Optional macro REGBANK_BYPASS_EN forwards the pending write to its output.
module register_bank
  import register_bank_pkg::*;
#(
  parameter int DATA_W   = register_bank_pkg::DATA_W,
  parameter int NUM_REGS = register_bank_pkg::NUM_REGS,
  parameter bit R0_ZERO  = 1'b1
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  hold,
  input  logic                  r_load,
  input  logic [DATA_W-1:0]     r_data,
  output logic [DATA_W-1:0]     r0,
  output logic [DATA_W-1:0]     r1,
  output logic [DATA_W-1:0]     r2,
  output logic [DATA_W-1:0]     r3,
  output logic [DATA_W-1:0]     r4,
  output logic [DATA_W-1:0]     r5,
  output logic [DATA_W-1:0]     r6,
  output logic [DATA_W-1:0]     r7,
  output logic [DATA_W-1:0]     regR,
  output logic                  wb_pending
);
  logic [DATA_W-1:0]     regs_q [NUM_REGS];
  logic [DATA_W-1:0]     view   [NUM_REGS];
  logic                  commit;
  logic [REG_ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0]     buf_data;
  wb_state_e             wb_state;
  logic                  r0_target;

  regbank_write_buffer #(.DATA_W(DATA_W)) u_wbuf (
    .clock    (clock),
    .resetn   (resetn),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .hold     (hold),
    .wr_ready (wr_ready),
    .commit   (commit),
    .buf_addr (buf_addr),
    .buf_data (buf_data),
    .state    (wb_state)
  );

  assign wb_pending = (wb_state == WB_FULL);
  // Writes aimed at a hardwired-zero r0 still occupy the buffer but are dropped.
  assign r0_target  = R0_ZERO && (buf_addr == '0);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (commit && !r0_target) begin
      regs_q[buf_addr] <= buf_data;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)     regR <= '0;
    else if (r_load) regR <= r_data;
  end

  always_comb begin
    view = regs_q;
`ifdef REGBANK_BYPASS_EN
    if (wb_pending && !r0_target) view[buf_addr] = buf_data;
`endif
  end

  assign r0 = view[0];
  assign r1 = view[1];
  assign r2 = view[2];
  assign r3 = view[3];
  assign r4 = view[4];
  assign r5 = view[5];
  assign r6 = view[6];
  assign r7 = view[7];
endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank against a queue-based write model.
module tb_register_bank;
  typedef struct packed {
    logic [2:0]  a;
    logic [15:0] d;
  } wr_t;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        wr_valid = 1'b0;
  logic        hold = 1'b0;
  logic        r_load = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [15:0] r_data = '0;
  logic        wr_ready, wb_pending;
  logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7, regR;
  logic [15:0] rr [8];

  int checks = 0;
  int errors = 0;

  logic [15:0] m_regs [8];
  logic [15:0] m_r;
  wr_t         pend_q[$];
  bit          last_ready = 1'b1;

  register_bank dut (
    .clock(clock), .resetn(resetn), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .hold(hold), .r_load(r_load),
    .r_data(r_data), .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5),
    .r6(r6), .r7(r7), .regR(regR), .wb_pending(wb_pending)
  );

  always #5 clock = ~clock;

  assign rr[0] = r0; assign rr[1] = r1; assign rr[2] = r2; assign rr[3] = r3;
  assign rr[4] = r4; assign rr[5] = r5; assign rr[6] = r6; assign rr[7] = r7;

  // Visible value of GPR i: committed value, or the pending write when bypass is built in.
  function automatic logic [15:0] exp_reg(int i);
`ifdef REGBANK_BYPASS_EN
    if (pend_q.size() != 0 && int'(pend_q[0].a) == i && i != 0) return pend_q[0].d;
`endif
    return m_regs[i];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_r = '0;
    pend_q.delete();
    last_ready = 1'b1;
  endtask

  // One clock edge: the pending write commits when hold is low, a new write is
  // taken when the buffer is empty or draining, R loads independently.
  task automatic step();
    @(posedge clock);
    begin
      bit  pend;
      bit  rdy;
      wr_t e;
      pend = (pend_q.size() != 0);
      rdy  = !pend || !hold;
      if (pend && !hold) begin
        e = pend_q.pop_front();
        if (e.a != 3'd0) m_regs[e.a] = e.d;
      end
      if (wr_valid && rdy) pend_q.push_back('{a: wr_addr, d: wr_data});
      if (r_load) m_r = r_data;
      last_ready = rdy;
    end
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    #3;
    checks++;
    if (wr_ready !== 1'b1 || wb_pending !== 1'b0 || regR !== 16'h0) begin
      errors++;
      $display("FAIL reset_ctrl: wr_ready=%b wb_pending=%b regR=%h, want 1 0 0000", wr_ready, wb_pending, regR);
    end
    #9 resetn = 1'b1;
    step();
    step();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rr[i] !== 16'h0) begin
        errors++;
        $display("FAIL reset_r%0d: got %h want 0000", i, rr[i]);
      end
    end
    checks++;
    if (wr_ready !== 1'b1 || wb_pending !== 1'b0 || regR !== 16'h0) begin
      errors++;
      $display("FAIL reset_idle: wr_ready=%b wb_pending=%b regR=%h, want 1 0 0000", wr_ready, wb_pending, regR);
    end
  endtask

  task automatic test_basic_write();
    wr_valid = 1'b1; wr_addr = 3'd3; wr_data = 16'd3; hold = 1'b0;
    step();
    wr_valid = 1'b0;
    #1;
    checks++;
    if (wb_pending !== 1'b1 || r3 !== exp_reg(3)) begin
      errors++;
      $display("FAIL basic_pending: wb_pending=%b r3=%h, want 1 %h", wb_pending, r3, exp_reg(3));
    end
    step();
    checks++;
    if (r3 !== 16'd3 || wb_pending !== 1'b0) begin
      errors++;
      $display("FAIL basic_commit: r3=%h wb_pending=%b, want 0003 0", r3, wb_pending);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rr[i] !== exp_reg(i)) begin
        errors++;
        $display("FAIL basic_others r%0d: got %h want %h", i, rr[i], exp_reg(i));
      end
    end
  endtask

  task automatic test_hold();
    wr_valid = 1'b1; wr_addr = 3'd5; wr_data = 16'h00AA; hold = 1'b0;
    step();
    wr_valid = 1'b0; hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (wr_ready !== 1'b0 || wb_pending !== 1'b1) begin
        errors++;
        $display("FAIL hold_ctrl c%0d: wr_ready=%b wb_pending=%b, want 0 1", c, wr_ready, wb_pending);
      end
      checks++;
`ifdef REGBANK_BYPASS_EN
      if (r5 !== 16'h00AA) begin
        errors++;
        $display("FAIL hold_r5 c%0d: got %h want 00aa", c, r5);
      end
`else
      if (r5 !== 16'h0000) begin
        errors++;
        $display("FAIL hold_r5 c%0d: got %h want 0000", c, r5);
      end
`endif
      step();
    end
    hold = 1'b0;
    step();
    checks++;
    if (r5 !== 16'h00AA || wb_pending !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: r5=%h wb_pending=%b, want 00aa 0", r5, wb_pending);
    end
  endtask

  task automatic test_back_to_back();
    wr_valid = 1'b1; wr_addr = 3'd2; wr_data = 16'h0011; hold = 1'b0;
    step();
    wr_data = 16'h0022;
    #1;
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready: got %b want 1", wr_ready);
    end
    step();
    wr_valid = 1'b0;
    #1;
    checks++;
    if (m_regs[2] !== 16'h0011 || r2 !== exp_reg(2)) begin
      errors++;
      $display("FAIL b2b_first: r2=%h want %h", r2, exp_reg(2));
    end
    step();
    checks++;
    if (r2 !== 16'h0022) begin
      errors++;
      $display("FAIL b2b_last: r2=%h want 0022", r2);
    end
  endtask

  task automatic test_r0_and_regR();
    wr_valid = 1'b1; wr_addr = 3'd0; wr_data = 16'hFFFF;
    r_load = 1'b1; r_data = 16'd9;
    step();
    wr_valid = 1'b0; r_load = 1'b0;
    #1;
    checks++;
    if (regR !== 16'd9 || r0 !== 16'h0 || wb_pending !== 1'b1) begin
      errors++;
      $display("FAIL r0_pending: regR=%h r0=%h wb_pending=%b, want 0009 0000 1", regR, r0, wb_pending);
    end
    step();
    checks++;
    if (r0 !== 16'h0 || regR !== 16'd9) begin
      errors++;
      $display("FAIL r0_commit: r0=%h regR=%h, want 0000 0009", r0, regR);
    end
  endtask

  task automatic test_reset_mid_write();
    wr_valid = 1'b1; wr_addr = 3'd7; wr_data = 16'h03FF; hold = 1'b0;
    step();
    wr_valid = 1'b0; hold = 1'b1;
`ifdef REGBANK_BYPASS_EN
    #1;
    checks++;
    if (r7 !== 16'h03FF) begin
      errors++;
      $display("FAIL bypass_r7: got %h want 03ff", r7);
    end
    #1;
`else
    #2;
`endif
    resetn = 1'b0;
    model_reset();
    #1;
    checks++;
    if (r7 !== 16'h0 || wb_pending !== 1'b0 || wr_ready !== 1'b1 || r5 !== 16'h0 || r2 !== 16'h0) begin
      errors++;
      $display("FAIL async_reset: r7=%h wb_pending=%b wr_ready=%b r5=%h r2=%h, want 0000 0 1 0000 0000",
               r7, wb_pending, wr_ready, r5, r2);
    end
    #2 resetn = 1'b1;
    hold = 1'b0;
    step();
    step();
    checks++;
    if (r7 !== 16'h0 || wb_pending !== 1'b0) begin
      errors++;
      $display("FAIL reset_drop: r7=%h wb_pending=%b, want 0000 0", r7, wb_pending);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if (!(wr_valid && !last_ready)) begin
        wr_valid = ($urandom_range(0, 3) != 0);
        wr_addr  = 3'($urandom_range(0, 7));
        wr_data  = 16'($urandom);
      end
      hold   = ($urandom_range(0, 3) == 0);
      r_load = ($urandom_range(0, 4) == 0);
      r_data = 16'($urandom);
      #1;
      checks++;
      if (wr_ready !== (pend_q.size() == 0 || !hold) || wb_pending !== (pend_q.size() != 0)) begin
        errors++;
        $display("FAIL rand_ctrl c%0d: wr_ready=%b wb_pending=%b", c, wr_ready, wb_pending);
      end
      checks++;
      if (regR !== m_r) begin
        errors++;
        $display("FAIL rand_regR c%0d: got %h want %h", c, regR, m_r);
      end
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (rr[i] !== exp_reg(i)) begin
          errors++;
          $display("FAIL rand_r%0d c%0d: got %h want %h", i, c, rr[i], exp_reg(i));
        end
      end
      step();
    end
    wr_valid = 1'b0; hold = 1'b0; r_load = 1'b0;
    step();
    step();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rr[i] !== m_regs[i]) begin
        errors++;
        $display("FAIL drain_r%0d: got %h want %h", i, rr[i], m_regs[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_hold();
    test_back_to_back();
    test_r0_and_regR();
    test_reset_mid_write();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
